// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters into a single UART transmitter.
// Optional burst locking is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GNT_W   = 2
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Done,
    output logic                 busy,
    output logic [GNT_W-1:0]     grant_id,
    output logic [15:0]          frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic [GNT_W-1:0] last_grant;
    logic             locked;
    logic             keep;
    logic             lock_hold;
    logic             found;
    logic [GNT_W-1:0] winner;
    logic [GNT_W:0]   sum;
    logic [7:0]       sel_byte;

`ifdef UART_ARB_LOCK_EN
    // The current owner keeps the UART while it both holds lock and still has data.
    assign keep      = req_lock[grant_id] && req_valid[grant_id];
    assign lock_hold = locked && keep;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign keep        = 1'b0;
    assign lock_hold   = 1'b0;
`endif

    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        if (lock_hold) begin
            found  = 1'b1;
            winner = grant_id;
        end else begin
            for (int unsigned k = 1; k <= unsigned'(NUM_REQ); k++) begin
                sum = {1'b0, last_grant} + (GNT_W+1)'(k);
                if (sum >= (GNT_W+1)'(NUM_REQ)) begin
                    sum = sum - (GNT_W+1)'(NUM_REQ);
                end
                if (!found && req_valid[sum[GNT_W-1:0]]) begin
                    found  = 1'b1;
                    winner = sum[GNT_W-1:0];
                end
            end
        end
    end

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
            if (winner == GNT_W'(i)) begin
                sel_byte = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (PRESETn && (state == IDLE) && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            o_TX_DV    <= 1'b0;
            o_TX_Byte  <= '0;
            grant_id   <= '0;
            last_grant <= GNT_W'(NUM_REQ - 1);
            frame_cnt  <= '0;
            locked     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    locked <= 1'b0;
                    if (found) begin
                        o_TX_Byte <= sel_byte;
                        grant_id  <= winner;
                        o_TX_DV   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    o_TX_DV <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (i_TX_Done) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= IDLE;
                        locked    <= keep;
                        if (!keep) begin
                            last_grant <= grant_id;
                        end
                    end
                end
                default: begin
                    o_TX_DV <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: grant vector table, scoreboarded frames and corner sequences.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           PCLK = 1'b0;
    logic           PRESETn = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_lock = '0;
    logic [N-1:0]   req_ready;
    logic           o_TX_DV;
    logic [7:0]     o_TX_Byte;
    logic           i_TX_Done = 1'b0;
    logic           busy;
    logic [1:0]     grant_id;
    logic [15:0]    frame_cnt;

    uart_tx_arbiter #(.NUM_REQ(N), .GNT_W(2)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .o_TX_DV   (o_TX_DV),
        .o_TX_Byte (o_TX_Byte),
        .i_TX_Done (i_TX_Done),
        .busy      (busy),
        .grant_id  (grant_id),
        .frame_cnt (frame_cnt)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] bval;
    } sb_t;

    typedef struct packed {
        logic [N-1:0] valid;
        logic [N-1:0] ready;
    } vec_t;

    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rem[N];
    logic [7:0]  dat[N];
    logic [15:0] exp_cnt = '0;
    vec_t        vec[6];
    int          lock_seq[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (rem[i] > 0);
            req_data[8*i +: 8] = dat[i];
        end
    endtask

    // Called right after a falling edge with the arbiter idle and requests already driven.
    task automatic run_frame(input int id, input bit spur, input int waitc);
        logic [7:0] b;
        sb_t        e;
        #1;
        b = dat[id];
        check("ready_win", 32'(req_ready), 32'(1 << id));
        check("busy_idle", 32'(busy), 0);
        e.id   = 3'(id);
        e.bval = b;
        sb_q.push_back(e);
        @(negedge PCLK);
        rem[id]--;
        dat[id] = dat[id] + 8'h11;
        drive();
        check("ready_start", 32'(req_ready), 0);
        check("busy_start", 32'(busy), 1);
        if (spur) i_TX_Done = 1'b1;
        @(negedge PCLK);
        i_TX_Done = 1'b0;
        check("dv_one_cycle", 32'(o_TX_DV), 0);
        check("cnt_in_wait", 32'(frame_cnt), 32'(exp_cnt));
        repeat (waitc) begin
            @(negedge PCLK);
            check("byte_hold", 32'(o_TX_Byte), 32'(b));
            check("ready_wait", 32'(req_ready), 0);
        end
        check("busy_wait", 32'(busy), 1);
        i_TX_Done = 1'b1;
        @(negedge PCLK);
        i_TX_Done = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("busy_done", 32'(busy), 0);
    endtask

    always @(negedge PCLK) begin
        sb_t e;
        if (PRESETn && o_TX_DV) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_dv actual=grant %0d byte %0h required=no pulse", grant_id, o_TX_Byte);
            end else begin
                e = sb_q.pop_front();
                check("sb_grant", 32'(grant_id), 32'(e.id));
                check("sb_byte", 32'(o_TX_Byte), 32'(e.bval));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{valid: 4'b0001, ready: 4'b0001};
        vec[1] = '{valid: 4'b1000, ready: 4'b1000};
        vec[2] = '{valid: 4'b1010, ready: 4'b0010};
        vec[3] = '{valid: 4'b1100, ready: 4'b0100};
        vec[4] = '{valid: 4'b0000, ready: 4'b0000};
        vec[5] = '{valid: 4'b1111, ready: 4'b0001};
`ifdef UART_ARB_LOCK_EN
        lock_seq = '{2, 2, 2, 0};
`else
        lock_seq = '{2, 0, 2, 0};
`endif
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            dat[i] = '0;
        end

        // Reset state, with requests pending so ready must still be suppressed.
        req_valid = 4'hF;
        #3;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dv", 32'(o_TX_DV), 0);
        check("rst_byte", 32'(o_TX_Byte), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_cnt", 32'(frame_cnt), 0);
        req_valid = '0;
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Combinational grant with last_grant at NUM_REQ-1; requests withdrawn before the edge.
        for (int t = 0; t < 6; t++) begin
            @(negedge PCLK);
            req_valid = vec[t].valid;
            #1;
            check("tbl_ready", 32'(req_ready), 32'(vec[t].ready));
            check("tbl_busy", 32'(busy), 0);
            #1;
            req_valid = '0;
        end
        @(negedge PCLK);
        check("tbl_no_transfer", 32'(busy), 0);

        // Single requester.
        rem[1] = 1;
        dat[1] = 8'h5A;
        drive();
        run_frame(1, 1'b0, 2);

        // Spurious done in IDLE, then in START.
        i_TX_Done = 1'b1;
        @(negedge PCLK);
        i_TX_Done = 1'b0;
        check("spur_idle_busy", 32'(busy), 0);
        check("spur_idle_cnt", 32'(frame_cnt), 32'(exp_cnt));
        rem[2] = 1;
        dat[2] = 8'hC3;
        drive();
        run_frame(2, 1'b1, 1);

        // Put last_grant at 1, then exercise the lock stimulus.
        rem[1] = 1;
        drive();
        run_frame(1, 1'b0, 0);
        req_lock = 4'b0100;
        rem[2] = 3;
        dat[2] = 8'h20;
        rem[0] = 2;
        dat[0] = 8'h00;
        drive();
        for (int k = 0; k < 4; k++) run_frame(lock_seq[k], 1'b0, 1);
        req_lock = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive();

        // Reset asserted mid-WAIT.
        @(negedge PCLK);
        rem[1] = 1;
        drive();
        #1;
        check("mid_ready", 32'(req_ready), 32'(4'b0010));
        sb_q.push_back('{id: 3'd1, bval: dat[1]});
        @(negedge PCLK);
        rem[1] = 0;
        drive();
        @(negedge PCLK);
        check("mid_in_wait", 32'(busy), 1);
        rem[0] = 1;
        rem[3] = 1;
        dat[0] = 8'hA0;
        dat[3] = 8'hA3;
        drive();
        #2;
        PRESETn = 1'b0;
        #1;
        check("mid_rst_dv", 32'(o_TX_DV), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cnt", 32'(frame_cnt), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_byte", 32'(o_TX_Byte), 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        exp_cnt = '0;
        check("mid_no_resume", 32'(busy), 0);
        run_frame(0, 1'b0, 0);
        run_frame(3, 1'b0, 0);

        // Fairness: all requesters valid for eight frames, last_grant now 3.
        for (int i = 0; i < N; i++) begin
            rem[i] = 2;
            dat[i] = 8'(16 * i + 1);
        end
        drive();
        for (int k = 0; k < 8; k++) run_frame(k % N, 1'b0, 0);
        check("fair_drained", 32'(req_valid), 0);

        // Counter wrap from 0xFFFF.
        force dut.frame_cnt = 16'hFFFF;
        @(negedge PCLK);
        release dut.frame_cnt;
        exp_cnt = 16'hFFFF;
        rem[2] = 1;
        drive();
        run_frame(2, 1'b0, 0);
        rem[3] = 1;
        drive();
        run_frame(3, 1'b0, 0);

        @(negedge PCLK);
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters; the legal range is 2..8.
REQ-002 The block SHALL have parameter GNT_W, default 2, meaning the grant index width; it SHALL equal clog2(NUM_REQ).
REQ-003 The block SHALL have port PCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port PRESETn, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester byte-available flags.
REQ-006 The block SHALL have port req_data, input, 8*NUM_REQ bits: per-requester bytes; requester i uses bits [8i+7:8i].
REQ-007 The block SHALL have port req_lock, input, NUM_REQ bits: per-requester burst-hold flags; the port is always present and is used only under REQ-030.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: accept strobe, at most one bit high.
REQ-009 The block SHALL have port o_TX_DV, output, 1 bit: one-cycle start pulse to the UART transmitter.
REQ-010 The block SHALL have port o_TX_Byte, output, 8 bits: the byte sent to the transmitter.
REQ-011 The block SHALL have port i_TX_Done, input, 1 bit: transmitter frame-complete pulse.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port grant_id, output, GNT_W bits: index of the current or most recent winner.
REQ-014 The block SHALL have port frame_cnt, output, 16 bits: count of completed frames.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, START and WAIT.
REQ-016 In IDLE with any req_valid bit high, the block SHALL select a winner by round-robin: search from last_grant+1 upward, modulo NUM_REQ.
REQ-017 In IDLE, req_ready[winner] SHALL be driven combinationally high in the same cycle as the valid; all other req_ready bits SHALL be 0.
REQ-018 A transfer SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-019 On a transfer, the block SHALL latch req_data[i] into o_TX_Byte, set grant_id to i, and move to START.
REQ-020 In START, o_TX_DV SHALL be high for exactly one cycle; the FSM then moves to WAIT.
REQ-021 o_TX_Byte SHALL be held stable from START through the end of WAIT.
REQ-022 In WAIT, i_TX_Done SHALL set last_grant to grant_id, increment frame_cnt, and move the FSM to IDLE.
REQ-023 frame_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-024 i_TX_Done received in IDLE or START SHALL be ignored.
REQ-025 req_ready SHALL be all-zero in START and WAIT.
REQ-026 A requester may deassert req_valid before it is accepted; that is legal, and the requester is then skipped with no side effect.
REQ-027 Latency SHALL be: valid in IDLE -> o_TX_DV one cycle later; i_TX_Done -> next accept one cycle later. The minimum spacing is 2 cycles plus the frame time.
REQ-028 Without REQ-030, a requester holding req_valid high continuously SHALL be granted at most once per NUM_REQ grants while other requesters are valid.

Reset
REQ-029 While PRESETn is low, at any time and including mid-frame, the block SHALL immediately force: FSM to IDLE; o_TX_DV=0; o_TX_Byte=0x00; grant_id=0; last_grant=NUM_REQ-1, so requester 0 has first priority; frame_cnt=0; busy=0; req_ready=0. No pending frame SHALL be resumed after reset.

Configuration
REQ-030 Macro UART_ARB_LOCK_EN SHALL control burst locking, as follows.
- Defined: at i_TX_Done, if req_lock[grant_id] and req_valid[grant_id] are both high, the FSM SHALL return to IDLE with only req_ready[grant_id] eligible; last_grant is not updated, so the same requester keeps the UART. The lock releases when req_lock or req_valid drops.
- Undefined: req_lock SHALL be ignored and pure round-robin SHALL apply.

Verification
REQ-031 Reset behaviour: assert PRESETn=0 mid-WAIT -> o_TX_DV=0, busy=0, frame_cnt=0 asynchronously; after release, valid on req 0 and req 3 together -> req 0 is granted first.
REQ-032 Single requester: req 1 valid with data 0x5A -> req_ready[1] high 1 cycle; o_TX_DV pulses the next cycle with o_TX_Byte=0x5A; i_TX_Done -> frame_cnt=1, busy=0.
REQ-033 Fairness: all 4 requesters valid continuously for 8 frames -> grant order 0,1,2,3,0,1,2,3.
REQ-034 Spurious done: i_TX_Done pulsed in IDLE and in START -> no state change and frame_cnt unchanged.
REQ-035 Wrap: preload 0xFFFF frames, then one more i_TX_Done -> frame_cnt=0x0000.
REQ-036 Lock with UART_ARB_LOCK_EN defined: req 2 has lock=1 and valid for 3 bytes while req 0 is valid -> grants are 2,2,2,0. With the macro undefined, the same stimulus -> grants are 2,0,2,0.
